// File: rtl/scan_pkg.sv
// Shared types and helpers for the hex display scan controller.
//   scan_phase_t : slot phase (anti-ghosting dead time vs. digit shown)
//   NIBBLE_W     : bits per hex digit
//   MAX_DIGITS   : widest display the helpers support
//   lz_mask()    : per-digit leading-zero suppression vector
package scan_pkg;

    typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_phase_t;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned LZ_W       = NIBBLE_W * MAX_DIGITS;

    // Bit i set when digit i (i > 0) and every digit above it up to n-1 are zero.
    // Digit 0 is never flagged so a zero value still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [LZ_W-1:0] value,
        input int unsigned     n
    );
        logic                  all_zero;
        logic [MAX_DIGITS-1:0] mask;
        all_zero = 1'b1;
        mask     = '0;
        for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
            if (i < int'(n)) begin
                all_zero = all_zero && (value[NIBBLE_W*i +: NIBBLE_W] == '0);
                mask[i]  = (i > 0) && all_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Digit slot timer: owns the per-slot cycle counter, the digit index and the
// blank/show phase. Outputs are the values that take effect on the next
// cycle, so the top level can register its display outputs in step with them.
//   clk, reset_n : clock, async active-low reset
//   idx          : digit index for the next cycle
//   phase        : slot phase for the next cycle
//   frame_end    : next cycle is the last cycle of a frame
module scan_slot_timer
    import scan_pkg::*;
#(
    parameter  int unsigned PRESCALE = 50000,
    parameter  int unsigned BLANK    = 16,
    parameter  int unsigned NDIGITS  = 4,
    localparam int unsigned IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [IDX_W-1:0] idx,
    output scan_phase_t      phase,
    output logic             frame_end
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    scan_phase_t      phase_q, phase_d;
    logic             slot_end;

    // Slot counter, digit index and phase transitions.
    always_comb begin
        slot_end = (cnt_q == CNT_W'(PRESCALE - 1));
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        phase_d = phase_q;
        case (phase_q)
            SCAN_BLANK: if (cnt_d == CNT_W'(BLANK)) phase_d = SCAN_SHOW;
            SCAN_SHOW:  if (slot_end)               phase_d = SCAN_BLANK;
            default:                                phase_d = SCAN_BLANK;
        endcase
        idx       = idx_d;
        phase     = phase_d;
        frame_end = (cnt_d == CNT_W'(PRESCALE - 1)) && (idx_d == IDX_W'(NDIGITS - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= SCAN_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed scan controller for an NDIGITS seven-segment hex display.
// Holds the displayed value, accepts updates over valid/ready into a pending
// register and swaps them in only at frame boundaries.
//   clk, reset_n            : clock, async active-low reset
//   load_valid/ready/data   : display value handshake (digit 0 in bits 3:0)
//   lz_blank_en             : leading-zero suppression enable
//   d                       : current digit nibble for the decoder
//   an                      : active-low anode enables
//   blank                   : force all segments off downstream
//   frame_done              : pulse on the last cycle of each frame
module hex_scan_driver
    import scan_pkg::*;
#(
    parameter  int unsigned NDIGITS  = 4,
    parameter  int unsigned PRESCALE = 50000,
    parameter  int unsigned BLANK    = 16,
    localparam int unsigned DATA_W   = NIBBLE_W * NDIGITS,
    localparam int unsigned IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                lz_blank_en,
    output logic [NIBBLE_W-1:0] d,
    output logic [NDIGITS-1:0]  an,
    output logic                blank,
    output logic                frame_done
);

    logic [IDX_W-1:0] idx_nxt;
    scan_phase_t      phase_nxt;
    logic             frame_end_nxt;

    scan_slot_timer #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK),
        .NDIGITS  (NDIGITS)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .idx       (idx_nxt),
        .phase     (phase_nxt),
        .frame_end (frame_end_nxt)
    );

    logic [DATA_W-1:0]     active_q, active_d;
    logic [DATA_W-1:0]     pending_q, pending_d;
    logic                  pend_full_q, pend_full_d;
    logic [NIBBLE_W-1:0]   d_q, d_d;
    logic [NDIGITS-1:0]    an_q, an_d;
    logic                  blank_q, blank_d;
    logic                  load_ready_q, load_ready_d;
    logic                  frame_done_q, frame_done_d;
    logic [MAX_DIGITS-1:0] lz_vec;
    logic                  suppress;
    logic                  show;

    // Handshake and frame-boundary swap. frame_done_q marks the boundary
    // cycle; accept and transfer are exclusive since accept needs pending empty.
    always_comb begin
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        if (frame_done_q && pend_full_q) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end
        if (load_valid && !pend_full_q) begin
            pending_d   = load_data;
            pend_full_d = 1'b1;
        end
    end

    // Output decode from the state the registers will hold next cycle, so the
    // registered outputs track the registered state without a lag.
    always_comb begin
        lz_vec   = lz_mask(LZ_W'(active_d), NDIGITS);
        d_d      = '0;
        suppress = 1'b0;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                d_d      = active_d[NIBBLE_W*i +: NIBBLE_W];
                suppress = lz_blank_en && lz_vec[i];
            end
        end
        show = (phase_nxt == SCAN_SHOW) && !suppress;
        an_d = '1;
        if (show) begin
            for (int i = 0; i < int'(NDIGITS); i++) begin
                if (idx_nxt == IDX_W'(i)) an_d[i] = 1'b0;
            end
        end
        blank_d      = !show;
        load_ready_d = !pend_full_d;
        frame_done_d = frame_end_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q     <= '0;
            pending_q    <= '0;
            pend_full_q  <= 1'b0;
            d_q          <= '0;
            an_q         <= '1;
            blank_q      <= 1'b1;
            load_ready_q <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
            d_q          <= d_d;
            an_q         <= an_d;
            blank_q      <= blank_d;
            load_ready_q <= load_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign d          = d_q;
    assign an         = an_q;
    assign blank      = blank_q;
    assign load_ready = load_ready_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver (NDIGITS=4, PRESCALE=8, BLANK=2).
// Accepted load values queue up as expected display values and are popped
// into the expected active value at each frame boundary; a negedge monitor
// compares every output against that expectation each cycle.
module tb_hex_scan_driver;

    localparam int ND    = 4;
    localparam int PS    = 8;
    localparam int BL    = 2;
    localparam int FRAME = ND * PS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        lz_blank_en = 1'b0;
    logic        load_ready;
    logic [3:0]  d;
    logic [3:0]  an;
    logic        blank;
    logic        frame_done;

    hex_scan_driver #(
        .NDIGITS  (ND),
        .PRESCALE (PS),
        .BLANK    (BL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .lz_blank_en (lz_blank_en),
        .d           (d),
        .an          (an),
        .blank       (blank),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur_exp;
    int          pos;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: frame position since reset, and expected active value.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos     <= 0;
            cur_exp <= 16'h0;
            exp_q.delete();
        end else begin
            if (pos == FRAME - 1 && exp_q.size() != 0) cur_exp <= exp_q.pop_front();
            else if (load_valid && exp_q.size() == 0) exp_q.push_back(load_data);
            pos <= (pos == FRAME - 1) ? 0 : pos + 1;
        end
    end

    // Per-cycle output monitor.
    always @(negedge clk) begin
        int         slot;
        int         c;
        logic       sup;
        logic       show;
        logic [3:0] one;
        logic [3:0] ean;
        logic [15:0] upper;
        if (reset_n) begin
            slot  = pos / PS;
            c     = pos % PS;
            upper = cur_exp >> (4 * slot);
            sup   = lz_blank_en && (slot > 0) && (upper == 16'h0);
            show  = (c >= BL) && !sup;
            one   = 4'b0001;
            ean   = show ? ~(one << slot) : 4'hF;
            check_eq("d",          32'(d),          32'(upper & 16'hF));
            check_eq("an",         32'(an),         32'(ean));
            check_eq("blank",      32'(blank),      32'(!show));
            check_eq("frame_done", 32'(frame_done), 32'(pos == FRAME - 1));
            check_eq("load_ready", 32'(load_ready), 32'(exp_q.size() == 0));
        end
    end

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_an"},         32'(an),         32'hF);
        check_eq({tag, "_blank"},      32'(blank),      32'h1);
        check_eq({tag, "_d"},          32'(d),          32'h0);
        check_eq({tag, "_load_ready"}, 32'(load_ready), 32'h1);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a value and hold valid until it is taken; called at a negedge.
    task automatic send(input logic [15:0] v);
        logic got;
        got        = 1'b0;
        load_data  = v;
        load_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (load_ready) begin
                @(negedge clk);
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        check_eq("send_accept", 32'(got), 32'h1);
    endtask

    task automatic wait_pos(input int p);
        for (int n = 0; n < 100; n++) begin
            if (pos == p) break;
            @(negedge clk);
        end
        check_eq("wait_pos", 32'(pos), 32'(p));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        run(3);
        check_reset_outs("rst");
        release_reset();

        // Scan order and slot timing.
        send(16'h12AF);
        run(80);

        // Back-pressure: second value waits for the boundary transfer.
        send(16'h1111);
        send(16'h2222);
        run(100);

        // Accept on the boundary cycle with pending empty: no bypass.
        wait_pos(FRAME - 1);
        load_data  = 16'h00C3;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        run(80);

        // Mid-frame reset discards a pending value.
        wait_pos(0);
        send(16'hBEEF);
        wait_pos(13);
        #2 reset_n = 1'b0;
        #1 check_reset_outs("midrst");
        lz_blank_en = 1'b1;
        release_reset();
        run(40);

        // Leading-zero suppression.
        send(16'h0007);
        run(80);
        send(16'h0000);
        run(80);
        send(16'h0400);
        run(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
